// File: rtl/i2c_slave_rx.sv
// I2C write-only slave receiver.
// Decodes START/STOP, matches a 7-bit address and loads a sub-address pointer
// from the first data byte. Each following byte becomes a single-cycle register
// write at an auto-incrementing address. Reads are NAKed, and the block then
// ignores the bus.
module i2c_slave_rx #(
  parameter logic [6:0] I2C_ADDR    = 7'h70,
  parameter int         SYNC_STAGES = 2     // must be >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  typedef struct packed {
    logic       en;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_req_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q, scl_d, sda_d;
  logic                   start_c, stop_c, scl_rise, scl_fall;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt, ptr, ptr_nxt, byte_in;
  logic       oe_q, oe_nxt, busy_q, busy_nxt;
  wr_req_t    wr_q, wr_nxt;

  assign scl_q = scl_sync[SYNC_STAGES-1];
  assign sda_q = sda_sync[SYNC_STAGES-1];

  // Synchronise the pad inputs. Keep a one-cycle-old copy for edge detection.
  // The preset to 1 matches an idle bus, so reset release shows no false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_q;
      sda_d    <= sda_q;
    end
  end

  // Bus conditions. START/STOP need only SCL high now. If SCL rises in the
  // same cycle as SDA moves, the START/STOP wins and no bit is sampled.
  assign start_c  = scl_q & sda_d & ~sda_q;
  assign stop_c   = scl_q & ~sda_d & sda_q;
  assign scl_rise = scl_q & ~scl_d;
  assign scl_fall = ~scl_q & scl_d;
  assign byte_in  = {shreg[6:0], sda_q};

  // Register all FSM state and outputs.
  // SDA is released asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      wr_q    <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      ptr     <= ptr_nxt;
      oe_q    <= oe_nxt;
      busy_q  <= busy_nxt;
      wr_q    <= wr_nxt;
    end
  end

  // Next-state logic: bit shifting, byte decode, and the ACK window.
  // The ACK window runs from the falling edge after bit 8
  // to the falling edge after bit 9.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    ptr_nxt     = ptr;
    oe_nxt      = oe_q;
    busy_nxt    = busy_q;
    wr_nxt      = wr_q;
    wr_nxt.en   = 1'b0;

    if (stop_c) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
      busy_nxt    = 1'b0;
    end else if (start_c) begin
      // Any partial byte in flight is simply dropped here.
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
    end else begin
      case (state)
        ADDR, SUB, DATA: begin
          if (scl_rise) begin
            shreg_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ADDR) begin
                if (byte_in[7:1] == I2C_ADDR && !byte_in[0]) begin
                  state_nxt = ADDR_ACK;
                  busy_nxt  = 1'b1;
                end else begin
                  state_nxt = IGNORE;
                  busy_nxt  = 1'b0;
                  oe_nxt    = 1'b0;
                end
              end else if (state == SUB) begin
                ptr_nxt   = byte_in;
                state_nxt = SUB_ACK;
              end else begin
                state_nxt = DATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, SUB_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_nxt = 1'b1;
              if (state == DATA_ACK) begin
                wr_nxt.en   = 1'b1;
                wr_nxt.addr = ptr;
                wr_nxt.data = shreg;
                ptr_nxt     = ptr + 8'd1;
              end
            end else begin
              oe_nxt      = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = (state == ADDR_ACK) ? SUB : DATA;
            end
          end
        end
        IGNORE:  oe_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe  = oe_q;
  assign busy    = busy_q;
  assign wr_en   = wr_q.en;
  assign wr_addr = wr_q.addr;
  assign wr_data = wr_q.data;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: a bit-level I2C master, a transaction-level model of
// expected ACKs and writes, and a per-cycle monitor of the output rules.
module tb_i2c_slave_rx;
  localparam int H = 4;  // clk cycles per quarter SCL period (clk = 16x SCL)

  logic       clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_bus, sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data;

  assign sda_bus = sda_m & ~sda_oe;  // open-drain wired AND

  always #5 clk = ~clk;

  i2c_slave_rx #(.I2C_ADDR(7'h70), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  int          checks = 0, errors = 0;
  int          wr_cnt = 0, ack_cnt = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  held_a, held_d, ptr_m;
  logic        prev_we, prev_oe;
  bit          ack_win = 0, matched = 0, started = 0;
  logic [7:0]  tx[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every-cycle checks of sda_oe windowing, write content/width and output hold.
  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        held_a  = 8'h00;
        held_d  = 8'h00;
        prev_we = 1'b0;
        prev_oe = 1'b0;
      end else begin
        if (!ack_win) chk("sda_oe_outside_ack", 32'(sda_oe), 32'd0);
        if (wr_en) begin
          wr_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_wr: got %h/%h with no write expected", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            checks--;
            chk("wr_addr_data", 32'({wr_addr, wr_data}), 32'(e));
          end
          chk("wr_en_width", 32'(prev_we), 32'd0);
          chk("wr_on_ack_rise", 32'({prev_oe, sda_oe}), 32'd1);
          held_a = wr_addr;
          held_d = wr_data;
        end else begin
          chk("wr_hold", 32'({wr_addr, wr_data}), 32'({held_a, held_d}));
        end
        prev_we = wr_en;
        prev_oe = sda_oe;
      end
    end
  endtask

  task automatic send_bit(input logic b, input bit arm, input bit ack_exp);
    sda_m = b;
    wait_clk(H);
    scl_m = 1'b1;
    wait_clk(2*H);
    scl_m = 1'b0;
    if (arm) ack_win = ack_exp;
    wait_clk(H);
  endtask

  // Ninth clock: release SDA and sample ACK mid-high. Optionally pulse reset first.
  task automatic ack_bit(input bit ack_exp, input bit busy_exp, input bit do_rst);
    bit ae, be;
    ae = ack_exp;
    be = busy_exp;
    sda_m = 1'b1;
    wait_clk(H);
    if (do_rst) begin
      chk("oe_before_rst", 32'(sda_oe), 32'd1);
      ack_win = 0;
      #2 rst_n = 1'b0;
      #1 chk("oe_async_release", 32'(sda_oe), 32'd0);
      rst_n = 1'b1;
      ae = 0;
      be = 0;
    end
    scl_m = 1'b1;
    wait_clk(H);
    chk("ack_bit", 32'(sda_bus), 32'(!ae));
    if (sda_bus == 1'b0) ack_cnt++;
    chk("busy_at_ack", 32'(busy), 32'(be));
    wait_clk(H);
    scl_m = 1'b0;
    wait_clk(H);
    ack_win = 0;
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wait_clk(H);
    scl_m = 1'b1;
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b0;
    wait_clk(H);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b1;
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(2*H);
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("oe_after_stop", 32'(sda_oe), 32'd0);
  endtask

  // Transaction model: byte 0 address, byte 1 pointer, then writes at ptr++.
  // Every full byte of a matched write is ACKed.
  task automatic xfer(input int n, input int part, input bit end_stop, input int rst_at);
    bit ae;
    if (!started) start_cond();
    matched = (tx[0][7:1] == 7'h70) && !tx[0][0];
    for (int i = 0; i < n; i++) begin
      ae = matched;
      if (matched && i == 1) ptr_m = tx[1];
      if (matched && i >= 2) begin
        exp_q.push_back({ptr_m, tx[i]});
        ptr_m = ptr_m + 8'd1;
      end
      for (int k = 7; k >= 0; k--) send_bit(tx[i][k], k == 0, ae);
      if (i == rst_at) begin
        ack_bit(0, 0, 1);
        matched = 0;
      end else begin
        ack_bit(ae, matched, 0);
      end
    end
    for (int k = 0; k < part; k++) send_bit(1'($urandom_range(1, 0)), 0, 0);
    if (end_stop) begin
      stop_cond();
      started = 0;
    end else begin
      start_cond();
      started = 1;
    end
  endtask

  initial begin
    int a0, w0, n, part, r;
    bit es;
    fork monitor(); join_none

    wait_clk(3);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // Normal three-byte write
    a0 = ack_cnt; w0 = wr_cnt;
    tx[0] = 8'hE0; tx[1] = 8'h0A; tx[2] = 8'h55; tx[3] = 8'h1F;
    xfer(4, 0, 1, -1);
    chk("t1_acks", 32'(ack_cnt - a0), 32'd4);
    chk("t1_writes", 32'(wr_cnt - w0), 32'd2);
    chk("t1_last", 32'({wr_addr, wr_data}), 32'h0B1F);

    // Wrong address
    a0 = ack_cnt; w0 = wr_cnt;
    tx[0] = 8'hE2; tx[1] = 8'h00;
    xfer(2, 0, 1, -1);
    chk("t2_acks", 32'(ack_cnt - a0), 32'd0);
    chk("t2_writes", 32'(wr_cnt - w0), 32'd0);

    // Read request is NAKed and ignored
    a0 = ack_cnt; w0 = wr_cnt;
    tx[0] = 8'hE1; tx[1] = 8'h12; tx[2] = 8'h34;
    xfer(3, 0, 1, -1);
    chk("t3_acks", 32'(ack_cnt - a0), 32'd0);
    chk("t3_writes", 32'(wr_cnt - w0), 32'd0);

    // Pointer wrap
    w0 = wr_cnt;
    tx[0] = 8'hE0; tx[1] = 8'hFF; tx[2] = 8'h11; tx[3] = 8'h22;
    xfer(4, 0, 1, -1);
    chk("t4_writes", 32'(wr_cnt - w0), 32'd2);
    chk("t4_last", 32'({wr_addr, wr_data}), 32'h0022);

    // Partial byte then repeated START
    w0 = wr_cnt;
    tx[0] = 8'hE0; tx[1] = 8'h05;
    xfer(2, 4, 0, -1);
    tx[0] = 8'hE0; tx[1] = 8'h06; tx[2] = 8'h77;
    xfer(3, 0, 1, -1);
    chk("t5_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t5_last", 32'({wr_addr, wr_data}), 32'h0677);

    // Reset during the sub-address ACK
    a0 = ack_cnt; w0 = wr_cnt;
    tx[0] = 8'hE0; tx[1] = 8'h10; tx[2] = 8'h33; tx[3] = 8'h44;
    xfer(4, 0, 1, 1);
    chk("t6_acks", 32'(ack_cnt - a0), 32'd1);
    chk("t6_writes", 32'(wr_cnt - w0), 32'd0);
    chk("t6_wr_addr", 32'(wr_addr), 32'd0);

    // Random transactions
    for (int t = 0; t < 25; t++) begin
      r = $urandom_range(9, 0);
      if (r < 6) tx[0] = 8'hE0;
      else if (r < 8) tx[0] = 8'hE1;
      else begin
        tx[0] = 8'($urandom_range(255, 0));
        if (tx[0][7:1] == 7'h70) tx[0][7:1] = 7'h2A;
      end
      n = $urandom_range(5, 1);
      for (int i = 1; i < n; i++) tx[i] = 8'($urandom_range(255, 0));
      part = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
      es = ($urandom_range(3, 0) != 0);
      xfer(n, part, es, -1);
    end
    if (started) begin
      tx[0] = 8'hE0; tx[1] = 8'h80; tx[2] = 8'h5A;
      xfer(3, 0, 1, -1);
    end
    wait_clk(8);
    chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 Parameter I2C_ADDR, default 7'h70: 7-bit slave address this block responds to.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages in the SCL/SDA input synchronisers, minimum 2.
REQ-003 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port scl_in, input, 1: raw I2C SCL from the pad, asynchronous to clk.
REQ-006 Port sda_in, input, 1: raw I2C SDA from the pad, asynchronous to clk.
REQ-007 Port sda_oe, output, 1: 1 drives SDA low (ACK); 0 releases SDA; never drives high.
REQ-008 Port wr_en, output, 1: single-clk strobe marking one completed register write.
REQ-009 Port wr_addr, output, 8: register sub-address for the write; valid while wr_en=1.
REQ-010 Port wr_data, output, 8: data byte for the write; valid while wr_en=1.
REQ-011 Port busy, output, 1: high from an address-matched START until STOP or NAK.

Function
REQ-012 scl_in and sda_in shall each pass through a SYNC_STAGES flip-flop synchroniser; all decoding uses the synchronised values and their previous-cycle copies.
REQ-013 START (also repeated START): SDA falling while SCL high; from any state, enter ADDR with the bit counter cleared.
REQ-014 STOP: SDA rising while SCL high; from any state, enter IDLE and set sda_oe=0 and busy=0.
REQ-015 Data bits shall be sampled MSB first on each synchronised SCL rising edge.
REQ-016 States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK, IGNORE.
REQ-017 ADDR: after 8 bits, if bits[7:1]==I2C_ADDR and bit0==0, go to ADDR_ACK and set busy=1; otherwise go to IGNORE with sda_oe=0.
REQ-018 A read request (bit0==1) shall be NAKed: go to IGNORE with no ACK and no write.
REQ-019 ACK timing: on the SCL falling edge after the 8th bit, set sda_oe=1; on the following SCL falling edge (end of 9th clock), set sda_oe=0.
REQ-020 ADDR_ACK then SUB: the 8 received bits load the sub-address pointer, followed by SUB_ACK.
REQ-021 SUB_ACK then DATA: after 8 bits, wr_en=1 for exactly one clk on the same clk where sda_oe rises, with wr_addr=pointer and wr_data=byte; then DATA_ACK.
REQ-022 The pointer shall increment by 1 modulo 256 after each write, so 8'hFF wraps to 8'h00.
REQ-023 DATA_ACK shall return to DATA for further bytes; writes are unlimited until STOP or START.
REQ-024 IGNORE: hold sda_oe=0 and wr_en=0; leave IGNORE only on START (to ADDR) or STOP (to IDLE).
REQ-025 A STOP or START arriving with a partial byte (<8 bits) shall discard that byte and shall not produce wr_en.
REQ-026 SCL/SDA edges that coincide within one clk shall not both be acted on; a START/STOP condition takes precedence over bit sampling.
REQ-027 wr_addr and wr_data shall hold their last values while wr_en=0.
REQ-028 Minimum supported clk shall be 8x the SCL rate.

Reset
REQ-029 While rst_n=0: state=IDLE, bit counter=0, pointer=8'h00, sda_oe=0, wr_en=0, wr_addr=8'h00, wr_data=8'h00, busy=0, and synchronisers preset to 1 (idle bus).
REQ-030 Reset asserted mid-transfer shall release SDA immediately and asynchronously; after release, the block ignores the bus until the next START.

Verification
REQ-031 START, 0xE0 (addr 0x70 W), 0x0A, 0x55, 0x1F, STOP -> four ACKs; wr_en pulses (0x0A,0x55) then (0x0B,0x1F); busy falls at STOP.
REQ-032 START, 0xE2 (addr 0x71 W), 0x00, STOP -> sda_oe stays 0 for the whole transfer, no wr_en, busy stays 0.
REQ-033 START, 0xE1 (addr 0x70 R) -> NAK (sda_oe=0 on 9th clock), no wr_en, IGNORE until STOP.
REQ-034 START, 0xE0, 0xFF, 0x11, 0x22, STOP -> writes (0xFF,0x11), then (0x00,0x22).
REQ-035 START, 0xE0, 0x05, 4 bits of data, repeated START, 0xE0, 0x06, 0x77, STOP -> single write (0x06,0x77); no write to 0x05.
REQ-036 rst_n pulsed low while sda_oe=1 during an ACK -> sda_oe=0 with no clk edge; following bytes up to STOP produce no ACK or write.
